joystick_adc_reader: RTL

JOYSTICK_ADC_READER -- requirements
Module: joystick_adc_reader

---
 rtl/joystick_adc_reader.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/joystick_adc_reader.sv
// Reads x (channel 0) then y (channel 1) from a 2-channel 10-bit SPI ADC as an
// unbreakable pair, and publishes the top 4 bits of each as joystick nibbles.
module joystick_adc_reader #(
  parameter int CLK_DIV  = 32,
  parameter int GAP_HALF = 2
) (
  input  logic       fastClock,
  input  logic       reset,
  input  logic       enable,
  input  logic       adcMiso,
  output logic       adcCsN,
  output logic       adcSclk,
  output logic       adcMosi,
  output logic [3:0] xOut,
  output logic [3:0] yOut,
  output logic       sampleValid,
  output logic       busy
);

  localparam int H  = CLK_DIV / 2;
  localparam int CW = (H > 1) ? $clog2(H) : 1;
  localparam int HN = (GAP_HALF > 32) ? GAP_HALF : 32;
  localparam int HW = $clog2(HN);

  typedef enum logic [2:0] {
    S_IDLE, S_CS_SETUP, S_SHIFT, S_CS_HOLD, S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [HW-1:0] half_q, half_d;
  logic          chan_q, chan_d;
  logic [9:0]    shreg_q, shreg_d;
  logic [3:0]    ch0_q, ch0_d;
  logic          cs_n_q, cs_n_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic [3:0]    x_q, x_d;
  logic [3:0]    y_q, y_d;
  logic          sv_q, sv_d;
  logic          busy_q, busy_d;

  logic          half_end;
  logic [HW-1:0] nh;

  assign half_end = (cyc_q == CW'(H - 1));
  assign nh       = half_q + HW'(1);

  always_comb begin
    state_d = state_q;
    cyc_d   = half_end ? '0 : cyc_q + CW'(1);
    half_d  = half_q;
    chan_d  = chan_q;
    shreg_d = shreg_q;
    ch0_d   = ch0_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    x_d     = x_q;
    y_d     = y_q;
    sv_d    = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        cyc_d  = '0;
        half_d = '0;
        if (enable) begin
          state_d = S_CS_SETUP;
          chan_d  = 1'b0;
          cs_n_d  = 1'b0;
          sclk_d  = 1'b0;
          mosi_d  = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_CS_SETUP: begin
        if (half_end) begin
          state_d = S_SHIFT;
          half_d  = '0;
        end
      end
      S_SHIFT: begin
        if (half_end) begin
          if (half_q == HW'(31)) begin
            state_d = S_CS_HOLD;
            half_d  = '0;
            sclk_d  = 1'b0;
            mosi_d  = 1'b0;
          end else begin
            half_d = nh;
            sclk_d = nh[0];
            // Odd half-periods start with a rising edge; edges 7..16 carry data.
            if (nh[0]) begin
              if (nh >= HW'(13)) shreg_d = {shreg_q[8:0], adcMiso};
            end else begin
              mosi_d = (nh == HW'(2)) | ((nh == HW'(4)) & chan_q) | (nh == HW'(6));
            end
          end
        end
      end
      S_CS_HOLD: begin
        if (half_end) begin
          state_d = S_GAP;
          half_d  = '0;
          cs_n_d  = 1'b1;
          if (!chan_q) begin
            ch0_d = shreg_q[9:6];
          end else begin
            x_d  = ch0_q;
            y_d  = shreg_q[9:6];
            sv_d = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (half_end) begin
          if (half_q == HW'(GAP_HALF - 1)) begin
            half_d = '0;
            // A pair is never split: enable only matters after channel 1.
            if (!chan_q || enable) begin
              state_d = S_CS_SETUP;
              chan_d  = ~chan_q;
              cs_n_d  = 1'b0;
              mosi_d  = 1'b1;
            end else begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
            end
          end else begin
            half_d = nh;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge fastClock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      half_q  <= '0;
      chan_q  <= 1'b0;
      shreg_q <= '0;
      ch0_q   <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      x_q     <= 4'h8;
      y_q     <= 4'h8;
      sv_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      half_q  <= half_d;
      chan_q  <= chan_d;
      shreg_q <= shreg_d;
      ch0_q   <= ch0_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sv_q    <= sv_d;
      busy_q  <= busy_d;
    end
  end

  assign adcCsN      = cs_n_q;
  assign adcSclk     = sclk_q;
  assign adcMosi     = mosi_q;
  assign xOut        = x_q;
  assign yOut        = y_q;
  assign sampleValid = sv_q;
  assign busy        = busy_q;

endmodule
